// File: rtl/pirdsp_pkg.sv
// pirdsp_pkg: shared mode encodings, widths and stage-1 record for the PIRDSP post-adder path.
package pirdsp_pkg;
    localparam logic [1:0] MODE_16X16     = 2'b00;
    localparam logic [1:0] MODE_SUM_16X16 = 2'b01;
    localparam int PROD_W    = 33;
    localparam int ACC_W_DEF = 48;

    typedef struct packed {
        logic [31:0] r0;
        logic [31:0] r1;
        logic        carry;
        logic [1:0]  mode;
        logic        sgn;
        logic        clear;
    } s1_t;
endpackage

// File: rtl/pirdsp_product_resolve.sv
// pirdsp_product_resolve: folds the multiplier's redundant partial results into a signed PROD_W product.
module pirdsp_product_resolve
    import pirdsp_pkg::*;
(
    input  logic [31:0]       result_0,
    input  logic [31:0]       result_1,
    input  logic              carry,
    input  logic [1:0]        mode,
    input  logic              sgn,
    output logic [PROD_W-1:0] prod
);
    logic [31:0] p32;
    logic [32:0] p33;

    // reserved modes fall through to the plain 16x16 resolution
    always_comb begin
        p32  = result_0 + result_1;
        p33  = {carry, result_0} + {1'b0, result_1};
        prod = (mode == MODE_SUM_16X16) ? p33 : {sgn & p32[31], p32};
    end
endmodule

// File: rtl/pirdsp_post_adder_acc.sv
// pirdsp_post_adder_acc: resolves PIRDSP partial products and accumulates them over a 2-stage valid/ready pipe.
// Define PIRDSP_POST_ADDER_SAT_EN to saturate on signed overflow with a sticky acc_overflow flag.
module pirdsp_post_adder_acc
    import pirdsp_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       result_0,
    input  logic [31:0]       result_1,
    input  logic              result_SIDM_carry,
    input  logic [1:0]        mode,
    input  logic              a_sign,
    input  logic              b_sign,
    input  logic              acc_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [PROD_W-1:0] prod_out,
    output logic              acc_overflow
);
    logic              adv;
    logic              s1_valid;
    s1_t               s1;
    logic [PROD_W-1:0] p;
    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_nxt;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    pirdsp_product_resolve u_resolve (
        .result_0 (s1.r0),
        .result_1 (s1.r1),
        .carry    (s1.carry),
        .mode     (s1.mode),
        .sgn      (s1.sgn),
        .prod     (p)
    );

`ifdef PIRDSP_POST_ADDER_SAT_EN
    logic ovf;

    always_comb begin
        p_ext   = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
        sum     = acc_out + p_ext;
        ovf     = (acc_out[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_out[ACC_W-1]);
        acc_nxt = s1.clear ? p_ext :
                  !ovf     ? sum   :
                  acc_out[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            acc_overflow <= 1'b0;
        else if (adv && s1_valid)
            acc_overflow <= !s1.clear && (acc_overflow || ovf);
`else
    always_comb begin
        p_ext   = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
        sum     = acc_out + p_ext;
        acc_nxt = s1.clear ? p_ext : sum;
    end

    assign acc_overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            prod_out  <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1        <= '{r0: result_0, r1: result_1, carry: result_SIDM_carry, mode: mode,
                           sgn: a_sign | b_sign, clear: acc_clear};
            out_valid <= s1_valid;
            if (s1_valid) begin
                prod_out <= p;
                acc_out  <= acc_nxt;
            end
        end
endmodule

// File: tb/tb_pirdsp_post_adder_acc.sv
// tb_pirdsp_post_adder_acc: directed vector table plus stall, overflow and async-reset sequences.
module tb_pirdsp_post_adder_acc;
    import pirdsp_pkg::*;

    localparam int ACC_W = 48;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       result_0;
    logic [31:0]       result_1;
    logic              result_SIDM_carry;
    logic [1:0]        mode;
    logic              a_sign;
    logic              b_sign;
    logic              acc_clear;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic [PROD_W-1:0] prod_out;
    logic              acc_overflow;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic [1:0]  md;
        logic        as;
        logic        bs;
        logic        c;
        logic [31:0] r0;
        logic [31:0] r1;
        logic        clr;
        logic [32:0] ep;
        logic [47:0] ea;
    } vec_t;

    vec_t tv[8];

    always #5 clk = ~clk;

    pirdsp_post_adder_acc #(.ACC_W(ACC_W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .result_0          (result_0),
        .result_1          (result_1),
        .result_SIDM_carry (result_SIDM_carry),
        .mode              (mode),
        .a_sign            (a_sign),
        .b_sign            (b_sign),
        .acc_clear         (acc_clear),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .acc_out           (acc_out),
        .prod_out          (prod_out),
        .acc_overflow      (acc_overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input vec_t v);
        mode = v.md; a_sign = v.as; b_sign = v.bs; result_SIDM_carry = v.c;
        result_0 = v.r0; result_1 = v.r1; acc_clear = v.clr;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        set_beat(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (lat < 8) begin
            @(negedge clk);
            if (out_valid) break;
            step();
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd2);
        chk({nm, "_prod"}, 64'(prod_out), 64'(v.ep));
        chk({nm, "_acc"}, 64'(acc_out), 64'(v.ea));
        step();
    endtask

    task automatic send_seq(input logic [31:0] start);
        vec_t v;
        int   n;
        for (int k = 0; k < 4; k++) begin
            v = '{2'b00, 1'b0, 1'b0, 1'b0, start + 32'(k), 32'd0, k == 0, 33'd0, 48'd0};
            set_beat(v);
            in_valid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 50);
            if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [47:0] exp_acc [4];
        tv[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 32'h10,        32'h5,        1'b1, 33'h0_0000_0015, 48'h0000_0000_0015};
        tv[1] = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0,        1'b0, 33'h1_8000_0000, 48'hFFFF_8000_0015};
        tv[2] = '{2'b01, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h1,        1'b1, 33'h1_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
        tv[3] = '{2'b00, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2,        1'b0, 33'h0_0000_0001, 48'h0000_0000_0000};
        tv[4] = '{2'b11, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0,        1'b0, 33'h1_FFFF_FFF0, 48'hFFFF_FFFF_FFF0};
        tv[5] = '{2'b00, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0,        1'b0, 33'h0_FFFF_FFF0, 48'h0000_FFFF_FFE0};
        tv[6] = '{2'b01, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFE, 48'hFFFF_FFFF_FFFE};
        tv[7] = '{2'b10, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1,        1'b1, 33'h1_8000_0000, 48'hFFFF_8000_0000};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        result_0 = '0; result_1 = '0; result_SIDM_carry = 1'b0;
        mode = 2'b00; a_sign = 1'b0; b_sign = 1'b0; acc_clear = 1'b0;
        #22;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_acc", 64'(acc_out), 64'd0);
        chk("rst_prod", 64'(prod_out), 64'd0);
        chk("rst_ovf", 64'(acc_overflow), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        step();
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(tv[i], $sformatf("vec%0d", i));

        // stall: out_ready low while 4 beats arrive, then drain in order
        out_ready = 1'b0;
        exp_acc = '{48'd1, 48'd3, 48'd6, 48'd10};
        fork
            send_seq(32'd1);
            begin
                repeat (6) @(negedge clk);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_acc_frozen", 64'(acc_out), 64'd1);
                chk("stall_prod_frozen", 64'(prod_out), 64'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk($sformatf("drain%0d_valid", k), 64'(out_valid), 64'd1);
                    chk($sformatf("drain%0d_acc", k), 64'(acc_out), 64'(exp_acc[k]));
                end
            end
        join
        step();
        step();
        chk("drain_done", 64'(out_valid), 64'd0);

        // overflow: 32769 * (2^32-1) crosses 2^47-1 on the final beat
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 32769; i++) begin
            v = '{2'b01, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, i == 0, 33'd0, 48'd0};
            set_beat(v);
            step();
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("ovf_valid", 64'(out_valid), 64'd1);
`ifdef PIRDSP_POST_ADDER_SAT_EN
        chk("ovf_acc", 64'(acc_out), 64'h7FFF_FFFF_FFFF);
        chk("ovf_flag", 64'(acc_overflow), 64'd1);
        run_vec('{2'b11, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0, 33'h1_FFFF_FFF0, 48'h7FFF_FFFF_FFEF}, "sticky");
        chk("sticky_flag", 64'(acc_overflow), 64'd1);
`else
        chk("ovf_acc", 64'(acc_out), 64'h8000_FFFF_7FFF);
        chk("ovf_flag", 64'(acc_overflow), 64'd0);
        run_vec('{2'b11, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0, 33'h1_FFFF_FFF0, 48'h8000_FFFF_7FEF}, "sticky");
        chk("sticky_flag", 64'(acc_overflow), 64'd0);
`endif
        run_vec('{2'b00, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0, 1'b1, 33'h1, 48'h1}, "clr_after_ovf");
        chk("clr_flag", 64'(acc_overflow), 64'd0);

        // async reset with both stages full
        out_ready = 1'b0;
        set_beat('{2'b00, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0, 1'b0, 33'd0, 48'd0});
        in_valid = 1'b1;
        step();
        set_beat('{2'b00, 1'b0, 1'b0, 1'b0, 32'h6, 32'h0, 1'b0, 33'd0, 48'd0});
        step();
        in_valid = 1'b0;
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_acc", 64'(acc_out), 64'd6);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_acc", 64'(acc_out), 64'd0);
        chk("arst_prod", 64'(prod_out), 64'd0);
        chk("arst_ovf", 64'(acc_overflow), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_idle", 64'(out_valid), 64'd0);
        run_vec('{2'b00, 1'b0, 1'b0, 1'b0, 32'h7, 32'h0, 1'b0, 33'h7, 48'h7}, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/pirdsp_post_adder_acc.md
Name: pirdsp_post_adder_acc

Overview:
- Downstream stage of the 16x16 PIRDSP multiplier.
- Consumes the redundant partial results (result_0, result_1, result_SIDM_carry) plus mode and sign flags, and resolves them into a true signed product.
- Accumulates products into a wide register and presents the result over a 2-stage valid/ready pipeline.
- Sits between the multiplier array and the DSP output/cascade logic.

Parameters:
- ACC_W, 48, accumulator and output width; must be >= 34.
- PROD_W, 33, resolved product width (fixed by the 16x16 multiplier; not for override).

Ports:
- clk  input  1  clock; all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  partial-result beat valid
- in_ready  output  1  stage accepts a beat this cycle
- result_0  input  32  multiplier partial result 0
- result_1  input  32  multiplier partial result 1
- result_SIDM_carry  input  1  extra carry bit for mode_sum
- mode  input  2  2'b00 = mode_16x16; 2'b01 = mode_sum_16x16; others reserved, treated as 2'b00
- a_sign  input  1  operand a signed
- b_sign  input  1  operand b signed
- acc_clear  input  1  this beat loads the accumulator instead of adding to it
- out_valid  output  1  accumulator result valid
- out_ready  input  1  consumer accepts result
- acc_out  output  ACC_W  accumulator value
- prod_out  output  PROD_W  resolved product of the beat that produced acc_out
- acc_overflow  output  1  sticky signed overflow flag

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, acc_out=0, prod_out=0, acc_overflow=0, stage-1 valid=0.
  - in_ready is combinational; it is therefore 1 while reset is held.
- Advance signal: advance = !out_valid | out_ready.
  - in_ready = advance.
  - A beat is accepted when in_valid & in_ready.
- Stage 1 (register): on advance, capture result_0, result_1, carry, mode, a_sign|b_sign, acc_clear and the accept flag as s1_valid.
- Stage 2 (resolve and accumulate), on advance:
  - out_valid <= s1_valid.
  - When s1_valid, resolve the product:
    - mode_16x16: p32 = result_0 + result_1 mod 2^32. If (a_sign|b_sign), sign-extend bit 31 to PROD_W; else zero-extend.
    - mode_sum_16x16: p33 = {carry, result_0} + {1'b0, result_1} mod 2^33, interpreted as two's complement.
  - prod_out <= p.
  - Accumulate: acc_out <= acc_clear ? sext(p) : acc_out + sext(p), computed in ACC_W bits.
  - acc_overflow is set if the addition's signed overflow occurs (operand signs equal, result sign differs). It is cleared only by reset or by an acc_clear beat.
  - When s1_valid=0 on advance, out_valid drops to 0; acc_out and prod_out hold.
- Stall (out_valid & !out_ready): all registers hold and in_ready=0. No beat is lost or duplicated.
- Latency: 2 cycles from accept to out_valid when unstalled. Throughput: 1 beat per cycle.
- Simultaneous out_ready and in_valid on a full pipe: output is consumed and the new beat is accepted in the same cycle.
- Reserved mode values behave exactly as mode_16x16.

Optional Feature:
- Macro: PIRDSP_POST_ADDER_SAT_EN.
- Defined: on signed overflow, acc_out clamps to the positive rail 2^(ACC_W-1)-1 or the negative rail -2^(ACC_W-1), and acc_overflow is still set sticky.
- Undefined: the accumulator wraps modulo 2^ACC_W and acc_overflow is tied to 0.

Decomposition:
- Shared package pirdsp_pkg holds:
  - mode constants MODE_16X16=2'b00 and MODE_SUM_16X16=2'b01;
  - PROD_W=33;
  - the default ACC_W.
- One natural sub-module, pirdsp_product_resolve: combinational; takes result_0, result_1, carry, mode and signed, and produces the PROD_W product. It is reused by the cascade path.

Test Plan:
- mode 00, unsigned, acc_clear=1, r0=32'h10, r1=32'h5 -> after 2 cycles out_valid=1, prod_out=21, acc_out=21.
- mode 01, signed, acc_clear=1, carry=1, r0=32'hFFFF_FFFE, r1=1 -> prod_out=33'h1_FFFF_FFFF (-1), acc_out=48'hFFFF_FFFF_FFFF.
- mode 00, a_sign=1, r0=32'h8000_0000, r1=0, acc_clear=0, starting from acc=21 -> prod=-2^31, acc_out=21-2^31.
- Back-to-back 4 beats with out_ready held low after the first beat -> in_ready=0, acc_out frozen. On release, the remaining 3 results appear on consecutive cycles in order.
- With ACC_W=48, accumulate +2^32-1 until past 2^47-1:
  - with PIRDSP_POST_ADDER_SAT_EN defined: acc_out=48'h7FFF_FFFF_FFFF and acc_overflow=1;
  - without it: acc_out wraps negative and acc_overflow=0.
- Assert reset_n low mid-stream with both stages full -> out_valid, acc_out and acc_overflow go to 0 immediately (asynchronously). The first post-reset beat with acc_clear=0 yields acc_out equal to its product.
